// File: rtl/line_clear_pkg.sv
// Shared constants, types and FSM states for the post-lock board sweep.
package line_clear_pkg;

    localparam int unsigned BOARD_W   = 10;
    localparam int unsigned BOARD_H   = 20;
    localparam int unsigned CELL_BITS = 3;
    localparam int unsigned ROW_BITS  = BOARD_W * CELL_BITS;
    localparam int unsigned ADDR_W    = $clog2(BOARD_H);

    typedef logic [ADDR_W-1:0]   row_addr_t;
    // Write pointer carries one extra bit so that stepping below row 0 is visible.
    typedef logic [ADDR_W:0]     wr_ptr_t;
    typedef logic [ROW_BITS-1:0] row_t;

    typedef enum logic [2:0] {
        LC_IDLE,
        LC_READ,
        LC_EVAL,
        LC_FILL,
        LC_SCORE,
        LC_DONE
    } lc_state_t;

endpackage

// File: rtl/line_clear_bcd_counter.sv
// Four-digit BCD score counter with synchronous clear and saturation at 9999.
module line_clear_bcd_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value,
    output logic        inc_ok
);

    logic [15:0] value_q;
    logic [15:0] value_inc;
    logic        carry;

    always_comb begin
        value_inc = value_q;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign inc_ok = inc && (value_q != 16'h9999);
    assign value  = value_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (inc_ok) begin
            value_q <= value_inc;
        end
    end

endmodule

// File: rtl/line_clear.sv
// Bottom-up full-row removal with downward compaction, then BCD scoring of cleared rows.
module line_clear
    import line_clear_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                score_clr,
    output logic [ADDR_W-1:0]   row_addr,
    input  logic [ROW_BITS-1:0] row_rdata,
    output logic                row_we,
    output logic [ROW_BITS-1:0] row_wdata,
    output logic                busy,
    output logic                done,
    output logic [2:0]          lines,
    output logic [15:0]         score,
    output logic                score_inc
);

    lc_state_t state_q, state_d;
    row_addr_t rd_q, rd_d;
    wr_ptr_t   wr_q, wr_d;
    wr_ptr_t   cleared_q, cleared_d;
    wr_ptr_t   scored_q, scored_d;
    logic [2:0] lines_q, lines_d;
    logic      row_full;
    logic      cnt_clr;
    logic      cnt_inc;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < int'(BOARD_W); c++) begin
            if (row_rdata[c*CELL_BITS +: CELL_BITS] == '0) row_full = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cleared_d = cleared_q;
        scored_d  = scored_q;
        lines_d   = lines_q;
        row_addr  = '0;
        row_we    = 1'b0;
        row_wdata = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            LC_IDLE: begin
                cnt_clr = score_clr;
                if (start) begin
                    state_d   = LC_READ;
                    rd_d      = row_addr_t'(BOARD_H - 1);
                    wr_d      = wr_ptr_t'(BOARD_H - 1);
                    cleared_d = '0;
                    scored_d  = '0;
                end
            end
            LC_READ: begin
                row_addr = rd_q;
                state_d  = LC_EVAL;
            end
            LC_EVAL: begin
                if (row_full) begin
                    cleared_d = cleared_q + wr_ptr_t'(1);
                end else begin
                    // A row already in its final slot needs no rewrite.
                    if (wr_q != {1'b0, rd_q}) begin
                        row_we    = 1'b1;
                        row_addr  = wr_q[ADDR_W-1:0];
                        row_wdata = row_rdata;
                    end
                    wr_d = wr_q - wr_ptr_t'(1);
                end
                if (rd_q == '0) begin
                    state_d = wr_d[ADDR_W] ? LC_SCORE : LC_FILL;
                end else begin
                    rd_d    = rd_q - row_addr_t'(1);
                    state_d = LC_READ;
                end
            end
            LC_FILL: begin
                row_we   = 1'b1;
                row_addr = wr_q[ADDR_W-1:0];
                wr_d     = wr_q - wr_ptr_t'(1);
                if (wr_q[ADDR_W-1:0] == '0) state_d = LC_SCORE;
            end
            LC_SCORE: begin
                if (cleared_q != '0) begin
                    cnt_inc  = 1'b1;
                    scored_d = scored_q + wr_ptr_t'(1);
                end
                if (cleared_q == '0 || scored_q == cleared_q - wr_ptr_t'(1)) begin
                    state_d = LC_DONE;
                    lines_d = cleared_q[2:0];
                end
            end
            LC_DONE: begin
                state_d = LC_IDLE;
            end
            default: begin
                state_d = LC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LC_IDLE;
            rd_q      <= row_addr_t'(BOARD_H - 1);
            wr_q      <= wr_ptr_t'(BOARD_H - 1);
            cleared_q <= '0;
            scored_q  <= '0;
            lines_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cleared_q <= cleared_d;
            scored_q  <= scored_d;
            lines_q   <= lines_d;
        end
    end

    line_clear_bcd_counter u_bcd_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .value   (score),
        .inc_ok  (score_inc)
    );

    assign busy  = (state_q != LC_IDLE);
    assign done  = (state_q == LC_DONE);
    assign lines = lines_q;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench: board memory model, table-driven sweeps, random boards, corner sequences.
module tb_line_clear;
    import line_clear_pkg::*;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic                score_clr;
    logic [ADDR_W-1:0]   row_addr;
    logic [ROW_BITS-1:0] row_rdata;
    logic                row_we;
    logic [ROW_BITS-1:0] row_wdata;
    logic                busy;
    logic                done;
    logic [2:0]          lines;
    logic [15:0]         score;
    logic                score_inc;

    line_clear dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .score_clr (score_clr),
        .row_addr  (row_addr),
        .row_rdata (row_rdata),
        .row_we    (row_we),
        .row_wdata (row_wdata),
        .busy      (busy),
        .done      (done),
        .lines     (lines),
        .score     (score),
        .score_inc (score_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ROW_BITS-1:0] mem [BOARD_H];
    logic [ROW_BITS-1:0] exp_board [BOARD_H];
    int wr_count;
    int total = 0;
    int bad   = 0;
    int model_score = 0;

    always @(posedge clk) begin
        row_rdata <= mem[row_addr];
        if (row_we) begin
            mem[row_addr] <= row_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [ROW_BITS-1:0] full_row(input int r);
        logic [ROW_BITS-1:0] x;
        for (int c = 0; c < int'(BOARD_W); c++) x[c*CELL_BITS +: CELL_BITS] = 3'(((r + c) % 7) + 1);
        return x;
    endfunction

    function automatic logic [ROW_BITS-1:0] part_row(input int r);
        logic [ROW_BITS-1:0] x;
        x = full_row(r);
        x[(r % 10)*CELL_BITS +: CELL_BITS] = '0;
        return x;
    endfunction

    function automatic bit is_full(input logic [ROW_BITS-1:0] x);
        for (int c = 0; c < int'(BOARD_W); c++) if (x[c*CELL_BITS +: CELL_BITS] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_masks(input logic [19:0] fm, input logic [19:0] pm);
        for (int r = 0; r < int'(BOARD_H); r++)
            mem[r] = fm[r] ? full_row(r) : (pm[r] ? part_row(r) : '0);
    endtask

    // Expected board: surviving rows keep their order and settle at the bottom.
    task automatic build_model(output int nfull);
        logic [ROW_BITS-1:0] kept [$];
        nfull = 0;
        for (int r = int'(BOARD_H) - 1; r >= 0; r--) begin
            if (is_full(mem[r])) nfull++;
            else kept.push_back(mem[r]);
        end
        for (int r = 0; r < int'(BOARD_H); r++) exp_board[r] = '0;
        for (int i = 0; i < kept.size(); i++) exp_board[int'(BOARD_H) - 1 - i] = kept[i];
    endtask

    task automatic check_board(input string name);
        int nbad = 0;
        for (int r = 0; r < int'(BOARD_H); r++) if (mem[r] !== exp_board[r]) nbad++;
        check(name, nbad, 0);
    endtask

    task automatic run_sweep(input int poke_a, input int poke_b, input int poke_clr, input bit watch,
                             output int lat, output int incs, output int dones,
                             output logic [2:0] got_lines, output logic [15:0] got_score);
        lat = -1; incs = 0; dones = 0; got_lines = '0; got_score = '0;
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start     = (k == poke_a) || (k == poke_b);
            score_clr = (k == poke_clr);
            if (score_inc) incs++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k; got_lines = lines; got_score = score;
                end
            end
            if (lat >= 0 && (!watch || k >= lat + 60)) break;
        end
        start = 1'b0;
        score_clr = 1'b0;
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic set_score(input int target);
        int lat, incs, dones, n;
        logic [2:0] gl;
        logic [15:0] gs;
        if (target < model_score) begin
            @(negedge clk); score_clr = 1'b1;
            @(negedge clk); score_clr = 1'b0;
            model_score = 0;
        end
        while (model_score < target) begin
            n = (target - model_score > 20) ? 20 : target - model_score;
            for (int r = 0; r < int'(BOARD_H); r++) mem[r] = (r >= 20 - n) ? full_row(r) : '0;
            run_sweep(0, 0, 0, 1'b0, lat, incs, dones, gl, gs);
            model_score += n;
        end
    endtask

    task automatic sweep_check(input string name, input int exp_lines, input int exp_score,
                               input int exp_incs, input bit empty_case);
        int lat, incs, dones, nfull;
        logic [2:0] gl;
        logic [15:0] gs;
        build_model(nfull);
        run_sweep(0, 0, 0, 1'b0, lat, incs, dones, gl, gs);
        check({name, "_lines"}, gl, exp_lines);
        check({name, "_score"}, gs, to_bcd(exp_score));
        check({name, "_incs"}, incs, exp_incs);
        check_board({name, "_board"});
        if (empty_case) begin
            check({name, "_latency"}, lat, 2 * BOARD_H + 2);
            check({name, "_writes"}, wr_count, 0);
        end
        model_score = exp_score;
    endtask

    typedef struct {
        logic [19:0] full_mask;
        logic [19:0] part_mask;
        int          start_score;
        int          exp_lines;
        int          exp_score;
        int          exp_incs;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int lat, incs, dones, nfull, es, k;
        logic [2:0] gl;
        logic [15:0] gs;

        vecs[0] = '{20'h00000, 20'h00000, 0,    0, 0,    0};
        vecs[1] = '{20'h80000, 20'h40000, 0,    1, 1,    1};
        vecs[2] = '{20'hA0000, 20'h50000, 1,    2, 3,    2};
        vecs[3] = '{20'hF0000, 20'h08408, 99,   4, 103,  4};
        vecs[4] = '{20'h01020, 20'hFEFDF, 103,  2, 105,  2};
        vecs[5] = '{20'hC0000, 20'h00001, 9998, 2, 9999, 1};
        vecs[6] = '{20'h00001, 20'h80000, 9999, 1, 9999, 0};

        reset_n = 1'b0; start = 1'b0; score_clr = 1'b0; wr_count = 0;
        for (int r = 0; r < int'(BOARD_H); r++) mem[r] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row_we", row_we, 0);
        check("rst_lines", lines, 0);
        check("rst_score", score, 0);
        check("rst_score_inc", score_inc, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_row_wdata", row_wdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Random boards, at most four full rows each.
        for (int s = 0; s < 25; s++) begin
            nfull = 0;
            for (int r = 0; r < int'(BOARD_H); r++) begin
                k = $urandom_range(0, 5);
                if (k == 0 && nfull < 4) begin
                    for (int c = 0; c < int'(BOARD_W); c++)
                        mem[r][c*CELL_BITS +: CELL_BITS] = 3'($urandom_range(1, 7));
                    nfull++;
                end else if (k <= 2) begin
                    mem[r] = '0;
                end else begin
                    for (int c = 0; c < int'(BOARD_W); c++)
                        mem[r][c*CELL_BITS +: CELL_BITS] = 3'($urandom_range(0, 7));
                    mem[r][$urandom_range(0, BOARD_W - 1)*CELL_BITS +: CELL_BITS] = '0;
                end
            end
            build_model(nfull);
            es = (model_score + nfull > 9999) ? 9999 : model_score + nfull;
            sweep_check("rand", nfull, es, es - model_score, 1'b0);
        end

        for (int v = 0; v < 7; v++) begin
            set_score(vecs[v].start_score);
            load_masks(vecs[v].full_mask, vecs[v].part_mask);
            sweep_check($sformatf("vec%0d", v), vecs[v].exp_lines, vecs[v].exp_score,
                        vecs[v].exp_incs, vecs[v].full_mask == 0 && vecs[v].part_mask == 0);
        end

        // score_clr together with start: sweep scores from 0000.
        load_masks(20'h80000, 20'h20000);
        build_model(nfull);
        score_clr = 1'b1;
        run_sweep(0, 0, 0, 1'b0, lat, incs, dones, gl, gs);
        check("clr_start_score", gs, 16'h0001);
        check("clr_start_lines", gl, 1);
        check_board("clr_start_board");

        // score_clr alone in idle.
        @(negedge clk); score_clr = 1'b1;
        @(negedge clk); score_clr = 1'b0;
        check("idle_clr_score", score, 16'h0000);

        // start and score_clr while busy are ignored; a single done only.
        load_masks(20'hC0000, 20'h20000);
        build_model(nfull);
        run_sweep(5, 30, 20, 1'b1, lat, incs, dones, gl, gs);
        check("busy_start_dones", dones, 1);
        check("busy_clr_score", gs, 16'h0002);
        check("busy_incs", incs, 2);
        check_board("busy_board");

        // Reset in cycle 10 of a sweep aborts it.
        load_masks(20'h80000, 20'h40000);
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) reset_n = 1'b0;
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_row_we", row_we, 0);
        check("abort_score", score, 16'h0000);
        check("abort_done", done, 0);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
